// File: rtl/line_number_former_pkg.sv
// Shared types and helpers for the vertical line-pair former: pairing phase,
// FSM states and the whole-sample symmetric mirror used at the frame edges.
package line_former_pkg;

    typedef enum logic {
        EXP_FORWARD,
        EXP_BACKWARD
    } expand_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Wide enough for any ADDR_W up to 64 once doubled and signed.
    localparam int MIRROR_W = 72;

    localparam logic [63:0] EXP_STR_FWD = {8'h00, "forward"};
    localparam logic [63:0] EXP_STR_BWD = "backward";

    function automatic bit expand_ok(input logic [63:0] s);
        return (s == EXP_STR_FWD) || (s == EXP_STR_BWD);
    endfunction

    function automatic expand_t to_expand(input logic [63:0] s);
        return (s == EXP_STR_BWD) ? EXP_BACKWARD : EXP_FORWARD;
    endfunction

    // Reflect about 0 and about V, then clamp so a one-line frame (V=0) yields 0.
    function automatic logic signed [MIRROR_W-1:0] mirror(
        input logic signed [MIRROR_W-1:0] x,
        input logic signed [MIRROR_W-1:0] v
    );
        logic signed [MIRROR_W-1:0] r;
        if (x[MIRROR_W-1]) begin
            r = -x;
        end else if (x > v) begin
            r = (v <<< 1) - x;
        end else begin
            r = x;
        end
        if (r[MIRROR_W-1]) begin
            r = '0;
        end else if (r > v) begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_number_former_mirror.sv
// Combinational symmetric mirror of a signed raw line index into [0, V].
// Zero latency; no flow control.
module line_mirror
    import line_former_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic signed [ADDR_W+2:0] x_i,
    input  logic        [ADDR_W-1:0] v_i,
    output logic        [ADDR_W-1:0] m_o
);

    logic signed [MIRROR_W-1:0] x_ext;
    logic signed [MIRROR_W-1:0] v_ext;

    assign x_ext = MIRROR_W'(x_i);
    assign v_ext = signed'({{(MIRROR_W-ADDR_W){1'b0}}, v_i});
    assign m_o   = ADDR_W'(mirror(x_ext, v_ext));

endmodule

// File: rtl/line_number_former.sv
// Emits {even, odd} line-index pairs of one frame with symmetric edge extension.
// Pair 0 appears 1 clk after new_frame_i; outputs hold while valid_o && !ready_i.
module line_number_former
    import line_former_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter logic [63:0] EXPAND_TYPE = {8'h00, "forward"}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              new_frame_i,
    input  logic [ADDR_W-1:0] vsize_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] even_line_num_o,
    output logic [ADDR_W-1:0] odd_line_num_o,
    output logic              last_line_o
);

    localparam expand_t EXP = to_expand(EXPAND_TYPE);
    localparam int      XW  = ADDR_W + 3;

    if (!expand_ok(EXPAND_TYPE)) begin : g_bad_expand
        $fatal(1, "line_number_former: EXPAND_TYPE must be forward or backward");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   v_q, v_d;
    logic                valid_q;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   even_q, even_d;
    logic [ADDR_W-1:0]   odd_q, odd_d;
    logic signed [XW-1:0] even_x, odd_x, v_x;

    // new_frame_i wins over a concurrent handshake; the pending pair is dropped.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        v_d     = v_q;
        if (new_frame_i) begin
            state_d = ST_RUN;
            k_d     = '0;
            v_d     = vsize_i;
        end else if (state_q == ST_RUN && ready_i) begin
            if (last_q) begin
                state_d = ST_IDLE;
            end else begin
                k_d = k_q + ADDR_W'(1);
            end
        end
    end

    // Raw indices are formed from the next-state counter so outputs can be registered.
    assign even_x = signed'({2'b00, k_d, 1'b0});
    assign odd_x  = (EXP == EXP_FORWARD) ? even_x + XW'(1) : even_x - XW'(1);
    assign v_x    = signed'({3'b000, v_d});
    assign last_d = (state_d == ST_RUN) &&
                    ((EXP == EXP_FORWARD) ? (odd_x >= v_x) : (even_x >= v_x));

    line_mirror #(.ADDR_W(ADDR_W)) u_mirror_even (
        .x_i (even_x),
        .v_i (v_d),
        .m_o (even_d)
    );

    line_mirror #(.ADDR_W(ADDR_W)) u_mirror_odd (
        .x_i (odd_x),
        .v_i (v_d),
        .m_o (odd_d)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            v_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            even_q  <= '0;
            odd_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            v_q     <= v_d;
            valid_q <= (state_d == ST_RUN);
            last_q  <= last_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
        end
    end

    assign valid_o         = valid_q;
    assign even_line_num_o = even_q;
    assign odd_line_num_o  = odd_q;
    assign last_line_o     = last_q;

endmodule

// File: tb/tb_line_number_former.sv
// Randomized bench for line_number_former: forward and backward instances
// compared against an arithmetic model of pair order, mirroring and last flag.
module tb_line_number_former;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          nf_f, nf_b;
    logic [AW-1:0] vsize;
    logic          ready;

    logic          f_vld, f_last, b_vld, b_last;
    logic [AW-1:0] f_e, f_o, b_e, b_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    line_number_former #(.ADDR_W(AW)) u_dut_fwd (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .new_frame_i     (nf_f),
        .vsize_i         (vsize),
        .ready_i         (ready),
        .valid_o         (f_vld),
        .even_line_num_o (f_e),
        .odd_line_num_o  (f_o),
        .last_line_o     (f_last)
    );

    line_number_former #(.ADDR_W(AW), .EXPAND_TYPE("backward")) u_dut_bwd (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .new_frame_i     (nf_b),
        .vsize_i         (vsize),
        .ready_i         (ready),
        .valid_o         (b_vld),
        .even_line_num_o (b_e),
        .odd_line_num_o  (b_o),
        .last_line_o     (b_last)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint m_ref(input longint x, input longint v);
        longint r;
        r = x;
        if (r < 0) r = -r;
        else if (r > v) r = 2 * v - r;
        if (r < 0) r = 0;
        if (r > v) r = v;
        return r;
    endfunction

    function automatic longint n_pairs(input bit bwd, input longint v);
        return bwd ? (v + 1) / 2 + 1 : v / 2 + 1;
    endfunction

    task automatic sample(input bit bwd, output logic vld, output longint e,
                          output longint o, output logic l);
        vld = bwd ? b_vld  : f_vld;
        e   = bwd ? b_e    : f_e;
        o   = bwd ? b_o    : f_o;
        l   = bwd ? b_last : f_last;
    endtask

    // Starts a frame and walks the expected pairs; stop_after>=0 abandons it mid-frame.
    task automatic run_frame(input bit bwd, input longint v, input int pct, input int stop_after);
        longint n, k, ee, eo, ge, go;
        logic   vld, l;
        int     cyc;
        bit     r;
        n = n_pairs(bwd, v);
        @(negedge clk);
        vsize = AW'(v);
        if (bwd) nf_b = 1'b1; else nf_f = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 2000) begin
            @(negedge clk);
            nf_f = 1'b0;
            nf_b = 1'b0;
            cyc++;
            sample(bwd, vld, ge, go, l);
            ee = m_ref(2 * k, v);
            eo = m_ref(bwd ? 2 * k - 1 : 2 * k + 1, v);
            chk(bwd ? "bwd_valid" : "fwd_valid", vld, 1);
            chk(bwd ? "bwd_even"  : "fwd_even",  ge, ee);
            chk(bwd ? "bwd_odd"   : "fwd_odd",   go, eo);
            chk(bwd ? "bwd_last"  : "fwd_last",  l, (k == n - 1));
            r = ($urandom_range(99) < pct);
            ready = r;
            if (r) begin
                k++;
                if (stop_after >= 0 && k == stop_after) break;
            end
        end
        if (stop_after < 0) chk("pairs_done", k, n);
        if (k == n) begin
            @(negedge clk);
            ready = 1'($urandom_range(1));
            sample(bwd, vld, ge, go, l);
            chk("idle_valid", vld, 0);
            chk("idle_last", l, 0);
            chk("idle_even_hold", ge, m_ref(2 * (n - 1), v));
            chk("idle_odd_hold", go, m_ref(bwd ? 2 * (n - 1) - 1 : 2 * (n - 1) + 1, v));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        nf_f  = 1'b0;
        nf_b  = 1'b0;
        ready = 1'b0;
        vsize = '0;
        #12;
        chk("rst_fwd_valid", f_vld, 0);
        chk("rst_fwd_even", f_e, 0);
        chk("rst_fwd_odd", f_o, 0);
        chk("rst_fwd_last", f_last, 0);
        chk("rst_bwd_valid", b_vld, 0);
        chk("rst_bwd_even", b_e, 0);
        chk("rst_bwd_odd", b_o, 0);
        chk("rst_bwd_last", b_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_frame", f_vld, 0);

        run_frame(1'b0, 15, 100, -1);
        run_frame(1'b0, 4, 100, -1);
        run_frame(1'b1, 15, 100, -1);
        run_frame(1'b1, 4, 100, -1);
        run_frame(1'b0, 0, 100, -1);
        run_frame(1'b1, 0, 100, -1);
        run_frame(1'b0, 15, 50, -1);

        // Restart mid-frame, with the restart colliding with a handshake.
        run_frame(1'b0, 15, 100, 3);
        run_frame(1'b0, 5, 100, -1);
        run_frame(1'b1, 64'hFFFF_FFFF, 60, 4);
        run_frame(1'b1, 7, 60, -1);
        run_frame(1'b0, 64'hFFFF_FFFE, 70, 3);
        run_frame(1'b0, 9, 70, -1);

        // Asynchronous reset in the middle of a frame.
        run_frame(1'b0, 15, 100, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", f_vld, 0);
        chk("async_rst_even", f_e, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", f_vld, 0);
        end

        for (int i = 0; i < 24; i++) begin
            bit     bwd;
            longint v;
            int     stop;
            bwd  = 1'($urandom_range(1));
            v    = longint'($urandom_range(40));
            stop = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : -1;
            run_frame(bwd, v, 30 + int'($urandom_range(70)), stop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
